// File: rtl/b2d_tone_gen_pkg.sv
// Shared constants, state type and half-period table for the BCD-to-tone receive path.
package b2d_pkg;

  localparam int CODE_W = 4;
  localparam int NOTE_N = 10;

  typedef enum logic {REST, PLAY} tone_state_t;

  // Half-periods in 1 MHz ticks: C4 D4 E4 F4 G4 A4 B4 C5 D5
  localparam logic [10:0] HALF_TBL [1:9] = '{
    11'd1911, 11'd1703, 11'd1517, 11'd1432, 11'd1276,
    11'd1136, 11'd1012, 11'd956,  11'd851
  };

  // Half-period for a note code; 0 for rest or invalid codes.
  function automatic logic [10:0] half_period(input logic [CODE_W-1:0] code);
    logic [10:0] r;
    r = '0;
    for (int unsigned i = 1; i <= 9; i++) begin
      if (code == CODE_W'(i)) r = HALF_TBL[i];
    end
    return r;
  endfunction

  // True for codes that select a playable note (1..9).
  function automatic logic is_note_code(input logic [CODE_W-1:0] code);
    return (code != '0) && (code < CODE_W'(NOTE_N));
  endfunction

endpackage

// File: rtl/b2d_tone_gen_if.sv
// Key-code input and note/tone outputs of the tone generator.
interface b2d_tone_gen_if;
  import b2d_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic [NOTE_N-1:0] note_onehot;
  logic              note_active;
  logic              code_err;
  logic              tone_out;

  modport master (
    output code_in,
    input  note_onehot, note_active, code_err, tone_out
  );

  modport slave (
    input  code_in,
    output note_onehot, note_active, code_err, tone_out
  );

endinterface

// File: rtl/b2d_tone_gen_key_debounce.sv
// 2-FF synchronizer followed by a stability counter; a code is accepted once
// the synchronized value has been seen unchanged long enough.
module key_debounce #(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] code_s;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key code into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      code_s <= '0;
    end else begin
      sync1  <= din;
      code_s <= sync1;
    end
  end

  // Restart the count on any change; accept the candidate when the count
  // reaches its limit and hold the count there until the next change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      dout <= '0;
    end else if (code_s != cand) begin
      cand <= code_s;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      dout <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/b2d_tone_gen.sv
// Receive end of the piano key-code path: debounce the BCD key code, decode
// it to a one-hot note vector and play a square wave for the held note.
module b2d_tone_gen
  import b2d_pkg::*;
#(
  parameter int PRESCALE     = 50,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  b2d_tone_gen_if.slave    bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [CODE_W-1:0] stable_code;
  logic [NOTE_N-1:0] onehot_r;
  logic              err_r;
  logic [PS_W-1:0]   ps_cnt;
  logic              tick;
  tone_state_t       state;
  logic [CODE_W-1:0] play_code;
  logic [10:0]       half_cnt;
  logic [10:0]       half_lim;
  logic              tone_r;

  key_debounce #(
    .WIDTH        (CODE_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.code_in),
    .dout  (stable_code)
  );

  // Registered decode of the accepted code; codes past the note range flag an error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_r <= NOTE_N'(1);
      err_r    <= 1'b0;
    end else if (stable_code < CODE_W'(NOTE_N)) begin
      onehot_r <= NOTE_N'(1) << stable_code;
      err_r    <= 1'b0;
    end else begin
      onehot_r <= '0;
      err_r    <= 1'b1;
    end
  end

  // Free-running prescaler; tick marks the wrap cycle.
  always_comb begin
    tick = (ps_cnt == PS_MAX);
  end

  // Advance the prescaler, wrapping at PRESCALE-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Terminal half-period count for the note currently playing.
  always_comb begin
    half_lim = half_period(play_code) - 11'd1;
  end

  // Tone FSM. play_code remembers which note is sounding so a change between
  // two valid notes is seen as a phase restart; that restart takes priority
  // over a coincident tick, which is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= REST;
      play_code <= '0;
      half_cnt  <= '0;
      tone_r    <= 1'b0;
    end else if (!is_note_code(stable_code)) begin
      state     <= REST;
      play_code <= '0;
      half_cnt  <= '0;
      tone_r    <= 1'b0;
    end else if ((state == REST) || (stable_code != play_code)) begin
      state     <= PLAY;
      play_code <= stable_code;
      half_cnt  <= '0;
      tone_r    <= 1'b0;
    end else if (tick) begin
      if (half_cnt == half_lim) begin
        tone_r   <= ~tone_r;
        half_cnt <= '0;
      end else begin
        half_cnt <= half_cnt + 11'd1;
      end
    end
  end

  assign bus.note_onehot = onehot_r;
  assign bus.code_err    = err_r;
  assign bus.note_active = (state == PLAY);
  assign bus.tone_out    = tone_r;

endmodule

// File: tb/tb_b2d_tone_gen.sv
// Bench for b2d_tone_gen: directed key-code sequences, a cycle model derived
// from the sampling/debounce/tone rules, plus literal latency and period checks.
module tb_b2d_tone_gen;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  b2d_tone_gen_if bus();

  b2d_tone_gen #(
    .PRESCALE     (1),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int half_ref [10] = '{0, 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956, 851};

  bit m_valid = 0;
  int m_sy0 = 0, m_sy1 = 0;   // code_in as seen one and two edges ago
  int m_hist[$];              // synchronized samples since reset
  int m_stable = 0;           // accepted code
  int m_d = 0;                // code shown on the outputs
  int m_n = 0;                // edge counter
  int m_start = 0;            // edge at which the current note started
  int m_tone = 0;

  function automatic bit note(input int c);
    return (c >= 1) && (c <= 9);
  endfunction

  always @(posedge clk) begin
    int old_st, prev_d;
    bit same;
    m_n++;
    if (!rst_n) begin
      m_sy0 = 0; m_sy1 = 0;
      m_hist.delete();
      m_hist.push_back(0);
      m_stable = 0; m_d = 0; m_tone = 0;
      m_valid = 1;
    end else begin
      old_st = m_stable;
      m_hist.push_back(m_sy1);
      if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
      if (m_hist.size() == DEB + 1) begin
        same = 1;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 0;
        if (same) m_stable = m_hist[0];
      end
      prev_d = m_d;
      m_d = old_st;
      m_sy1 = m_sy0;
      m_sy0 = int'(bus.code_in);
      if (note(m_d)) begin
        if (!note(prev_d) || prev_d != m_d) m_start = m_n;
        m_tone = ((m_n - m_start) / half_ref[m_d]) % 2;
      end else begin
        m_tone = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("onehot", int'(bus.note_onehot), (m_d <= 9) ? (1 << m_d) : 0);
      check("active", int'(bus.note_active), int'(note(m_d)));
      check("err",    int'(bus.code_err),    int'(m_d > 9));
      check("tone",   int'(bus.tone_out),    m_tone);
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_active(input int max, output int took);
    took = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.note_active === 1'b1) begin took = i; return; end
    end
  endtask

  task automatic wait_onehot(input int val, input int max, output int took);
    took = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (int'(bus.note_onehot) == val) begin took = i; return; end
    end
  endtask

  task automatic wait_tone(input int val, input int max, output int took);
    took = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (int'(bus.tone_out) == val) begin took = i; return; end
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t, a, b;
    bus.code_in = 4'd6;
    rst_n = 1'b0;

    // 1: reset held with a key pressed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_onehot", int'(bus.note_onehot), 1);
      check("rst_active", int'(bus.note_active), 0);
      check("rst_tone",   int'(bus.tone_out), 0);
    end
    rst_n = 1'b1;

    // 2: clean press of 6 (2 sync + candidate + 4 counts + 1 decode edges)
    wait_active(40, t);
    check("press_latency", t, 8);
    check("press_onehot", int'(bus.note_onehot), 10'h040);
    wait_tone(1, 1300, t);
    check("a4_first_half", t, 1136);
    wait_tone(0, 1300, t);
    check("a4_second_half", t, 1136);

    // 3: glitch shorter than the debounce window
    bus.code_in = 4'd0;
    wait_onehot(1, 30, t);
    check("rest_reached", int'(t > 0), 1);
    repeat (6) @(negedge clk);
    bus.code_in = 4'd9;
    repeat (3) @(negedge clk);
    bus.code_in = 4'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("glitch_onehot", int'(bus.note_onehot), 1);
      check("glitch_tone",   int'(bus.tone_out), 0);
    end

    // 4: invalid code, then C4
    bus.code_in = 4'd12;
    wait_onehot(0, 30, t);
    check("inv_seen", int'(t > 0), 1);
    repeat (5) @(negedge clk);
    check("inv_err",    int'(bus.code_err), 1);
    check("inv_active", int'(bus.note_active), 0);
    check("inv_tone",   int'(bus.tone_out), 0);
    bus.code_in = 4'd1;
    wait_active(30, t);
    check("c4_active", int'(t > 0), 1);
    check("c4_err", int'(bus.code_err), 0);
    wait_tone(1, 2100, t);
    check("c4_first_half", t, 1911);
    wait_tone(0, 2100, a);
    wait_tone(1, 2100, b);
    check("c4_period", a + b, 3822);

    // 5: switch 6 -> 8 while tone is high
    bus.code_in = 4'd6;
    wait_onehot(10'h040, 30, t);
    check("a4_again", int'(t > 0), 1);
    wait_tone(1, 1300, t);
    check("a4_restart_half", t, 1136);
    repeat (100) @(negedge clk);
    bus.code_in = 4'd8;
    wait_onehot(10'h100, 30, t);
    check("c5_seen", int'(t > 0), 1);
    check("c5_phase_reset", int'(bus.tone_out), 0);
    wait_tone(1, 1100, t);
    check("c5_first_half", t, 956);
    wait_tone(0, 1100, t);
    check("c5_second_half", t, 956);

    // 6: reset pulse while E4 plays
    bus.code_in = 4'd3;
    wait_onehot(10'h008, 30, t);
    check("e4_seen", int'(t > 0), 1);
    wait_tone(1, 1600, t);
    check("e4_first_half", t, 1517);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tone",   int'(bus.tone_out), 0);
    check("midrst_onehot", int'(bus.note_onehot), 1);
    check("midrst_active", int'(bus.note_active), 0);
    rst_n = 1'b1;
    wait_active(40, t);
    check("redebounce_latency", t, 8);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
